// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_seq_pkg;

    // Sequencer states. The encoding is visible on state_o for debug.
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    // Width of the shared cycle counter: enough bits for the largest terminal count.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by reset.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at the bottom; the top flop is the safe output.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Synchronizer chain register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock,
// then releases core reset. Retries on lock timeout, re-sequences on lock loss.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               pll_locked_i,
    input  logic                               relock_req,
    output logic                               pll_rst,
    output logic                               sys_rst_n,
    output logic                               pll_ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [2:0]                         state_o
);

    localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    logic          lock_s;
    pll_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          pll_ready_q, pll_ready_d;
    logic          fault_q, fault_d;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d_i   (pll_locked_i),
        .q_o   (lock_s)
    );

    // Next state, counters, and outputs; outputs follow the next state so the
    // registered outputs always line up with the registered state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_q;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + RW'(1);
                        state_d = RESET_PLL;
                    end
                end
            end
            STABLE: begin
                // A dropout restarts the lock wait with a fresh timeout, not a retry.
                if (!lock_s)                   state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = RUN;
            end
            RUN: begin
                // Counter parked: RUN can last forever and must not wrap.
                cnt_d = '0;
                if (!lock_s || relock_req) state_d = RESET_PLL;
            end
            FAULT: begin
                cnt_d = '0;
                if (relock_req) begin
                    retry_d = '0;
                    state_d = RESET_PLL;
                end
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;
        if (state_d == RUN && state_q != RUN) retry_d = '0;

        pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAULT);
        sys_rst_n_d = (state_d == RUN);
        pll_ready_d = (state_d == RUN);
        fault_d     = (state_d == FAULT);
    end

    // State, counters and output registers; reset drives the safe values at once.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            pll_ready_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            pll_ready_q <= pll_ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign pll_ready = pll_ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with small simulation parameters.
module tb_pll_lock_sequencer;

    localparam int RSTP = 4;
    localparam int TO   = 20;
    localparam int STB  = 8;
    localparam int MAXR = 2;
    localparam int SYNC = 2;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked_i;
    logic       relock_req;
    logic       pll_rst, sys_rst_n, pll_ready, fault;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (RSTP),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_STABLE_CYCLES  (STB),
        .MAX_RETRIES         (MAXR),
        .SYNC_STAGES         (SYNC)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked_i (pll_locked_i),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .pll_ready    (pll_ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .state_o      (state_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase (0 pulse, 1 wait, 2 stable, 3 run, 4 fault),
    // cycles left in the phase (countdown), timeouts seen, and the lock
    // samples still in flight through the synchronizer.
    int             m_ph    = 0;
    int             m_left  = RSTP;
    int             m_tries = 0;
    logic [SYNC-1:0] m_hist = '0;

    function automatic int plen(input int p);
        if (p == 0) return RSTP;
        if (p == 1) return TO;
        if (p == 2) return STB;
        return 0;
    endfunction

    // Advance the model one refclk edge using the inputs present before the edge.
    always @(posedge refclk or negedge rst_n) begin : model
        int   ph, left, tries, nph;
        logic ls;
        if (!rst_n) begin
            m_ph    <= 0;
            m_left  <= RSTP;
            m_tries <= 0;
            m_hist  <= '0;
        end else begin
            ph = m_ph; left = m_left; tries = m_tries; nph = ph;
            ls = m_hist[SYNC-1];
            case (ph)
                0: begin left--; if (left == 0) nph = 1; end
                1: begin
                    if (ls) nph = 2;
                    else begin
                        left--;
                        if (left == 0) begin
                            if (tries == MAXR) nph = 4;
                            else begin tries++; nph = 0; end
                        end
                    end
                end
                2: begin
                    if (!ls) nph = 1;
                    else begin left--; if (left == 0) nph = 3; end
                end
                3: if (!ls || relock_req) nph = 0;
                default: if (relock_req) begin tries = 0; nph = 0; end
            endcase
            if (nph != ph) begin
                left = plen(nph);
                if (nph == 3) tries = 0;
            end
            m_ph    <= nph;
            m_left  <= left;
            m_tries <= tries;
            m_hist  <= {m_hist[SYNC-2:0], pll_locked_i};
        end
    end

    // Every cycle, compare all outputs with the model away from the active edge.
    always @(negedge refclk) begin
        chk("m_pll_rst",   pll_rst,   (m_ph == 0 || m_ph == 4));
        chk("m_sys_rst_n", sys_rst_n, (m_ph == 3));
        chk("m_pll_ready", pll_ready, (m_ph == 3));
        chk("m_fault",     fault,     (m_ph == 4));
        chk("m_retry_cnt", retry_cnt, m_tries);
        chk("m_state",     state_o,   m_ph);
    end

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int n = 0;
        while (state_o !== s && n < budget) begin
            @(negedge refclk);
            n++;
        end
        chk(nm, state_o, s);
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pll_rst"},   pll_rst,   1);
        chk({tag, "_sys_rst_n"}, sys_rst_n, 0);
        chk({tag, "_pll_ready"}, pll_ready, 0);
        chk({tag, "_fault"},     fault,     0);
        chk({tag, "_retry"},     retry_cnt, 0);
        chk({tag, "_state"},     state_o,   0);
    endtask

    initial begin
        int   n, rises;
        logic prev;
        logic [1:0] rec [0:3];

        rst_n = 1'b0; pll_locked_i = 1'b0; relock_req = 1'b0;
        repeat (3) @(negedge refclk);
        check_reset_outputs("reset");

        // 1: first bring-up, pulse width and lock-to-release latency
        rst_n = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 50) begin n++; @(negedge refclk); end
        chk("t1_pll_rst_width", n, RSTP);
        repeat (3) @(negedge refclk);
        pll_locked_i = 1'b1;
        n = 0;
        do begin @(posedge refclk); #1; n++; end while (sys_rst_n !== 1'b1 && n < 100);
        chk("t1_lock_latency", n, SYNC + STB + 1);
        chk("t1_pll_ready", pll_ready, 1);
        @(negedge refclk);

        // 3: lock loss in RUN for 5 cycles
        pll_locked_i = 1'b0;
        fork begin repeat (5) @(negedge refclk); pll_locked_i = 1'b1; end join_none
        n = 0;
        do begin @(posedge refclk); #1; n++; end while (sys_rst_n !== 1'b0 && n < 50);
        chk("t3_drop_latency", n, SYNC + 1);
        chk("t3_ready_low", pll_ready, 0);
        chk("t3_pll_rst_up", pll_rst, 1);
        n = 0;
        do begin @(posedge refclk); #1; n++; end while (pll_rst !== 1'b0 && n < 50);
        chk("t3_pll_rst_width", n, RSTP);
        @(negedge refclk);
        wait_state(3'd3, 100, "t3_relock_run");

        // 5: relock_req coincident with lock loss -> one pulse only
        pll_locked_i = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        pll_locked_i = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (pll_rst === 1'b1) n++;
            @(negedge refclk);
        end
        chk("t5_single_pulse_cycles", n, RSTP);
        wait_state(3'd3, 100, "t5_back_run");

        // 5b: relock_req in WAIT_LOCK is ignored
        pll_locked_i = 1'b0;
        wait_state(3'd1, 50, "t5_reach_wait");
        @(negedge refclk);
        pulse_relock();
        chk("t5_relock_ignored", state_o, 1);
        chk("t5_no_pulse", pll_rst, 0);
        pll_locked_i = 1'b1;
        wait_state(3'd3, 100, "t5_wait_run");

        // 4: single-cycle dropouts in STABLE
        for (int k = 0; k < 2; k++) begin
            if (k == 0) pulse_relock();
            wait_state(3'd2, 50, "t4_reach_stable");
            repeat (4) @(negedge refclk);
            pll_locked_i = 1'b0;
            @(negedge refclk);
            pll_locked_i = 1'b1;
            wait_state(3'd1, 10, "t4_back_to_wait");
            chk("t4_retry_unchanged", retry_cnt, 0);
        end
        wait_state(3'd3, 100, "t4_clean_run");

        // 2: no lock at all -> retries then FAULT
        pll_locked_i = 1'b0;
        prev = pll_rst; rises = 0; n = 0;
        while (fault !== 1'b1 && n < 500) begin
            @(negedge refclk);
            n++;
            if (pll_rst === 1'b1 && prev === 1'b0 && fault !== 1'b1) begin
                if (rises < 4) rec[rises] = retry_cnt;
                rises++;
            end
            prev = pll_rst;
        end
        chk("t2_pulses", rises, MAXR + 1);
        chk("t2_retry_seq0", rec[0], 0);
        chk("t2_retry_seq1", rec[1], 1);
        chk("t2_retry_seq2", rec[2], 2);
        chk("t2_fault", fault, 1);
        chk("t2_pll_rst", pll_rst, 1);
        chk("t2_sys_rst_n", sys_rst_n, 0);
        chk("t2_retry_cnt", retry_cnt, MAXR);
        repeat (5) @(negedge refclk);
        pll_locked_i = 1'b1;
        pulse_relock();
        chk("t2_relock_state", state_o, 0);
        chk("t2_relock_retry", retry_cnt, 0);
        chk("t2_relock_fault", fault, 0);
        wait_state(3'd3, 100, "t2_recover_run");

        // 6: asynchronous reset during STABLE, then during RUN
        pulse_relock();
        wait_state(3'd2, 50, "t6_reach_stable");
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_stable");
        repeat (2) @(negedge refclk);
        rst_n = 1'b1;
        wait_state(3'd3, 100, "t6_restart_run");
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_run");
        repeat (2) @(negedge refclk);
        rst_n = 1'b1;
        wait_state(3'd3, 100, "t6_restart_run2");

        // Randomized lock activity, relock requests and occasional resets.
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            len = $urandom_range(1, 60);
            pll_locked_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge refclk);
                rst_n = 1'b1;
            end
            for (int c = 0; c < len; c++) begin
                relock_req = ($urandom_range(0, 19) == 0);
                @(negedge refclk);
            end
            relock_req = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
